// File: rtl/flash_mem_pkg.sv
// flash_mem_pkg: shared types and constants for the
// flash memory read responder.
package flash_mem_pkg;

  localparam int FLASH_DATA_W  = 32;
  localparam int FLASH_BURST_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/flash_valid_delay.sv
// flash_valid_delay: DEPTH-stage valid shift register that
// tracks beats in flight through the ROM read pipeline.
module flash_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  output logic valid_out,
  output logic empty
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // shift one stage per cycle, new beat enters stage 0
  always_comb begin
    sr_d    = '0;
    sr_d[0] = valid_in;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_out = sr_q[DEPTH-1];
  assign empty     = ~|sr_q;

endmodule

// File: rtl/flash_mem_responder.sv
// flash_mem_responder: Avalon-MM read-only slave with wait
// states, bursts and byte masking in front of a sync ROM.
module flash_mem_responder
  import flash_mem_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int WAIT_STATES = 2,
  parameter int ROM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        flash_mem_address,
  input  logic                     flash_mem_read,
  input  logic [3:0]               flash_mem_byteenable,
  input  logic [FLASH_BURST_W-1:0] flash_mem_burstcount,
  output logic                     flash_mem_waitrequest,
  output logic [FLASH_DATA_W-1:0]  flash_mem_readdata,
  output logic                     flash_mem_readdatavalid,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [FLASH_DATA_W-1:0]  rom_q
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  logic [FLASH_BURST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]                be_q, be_d;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic [FLASH_DATA_W-1:0]   rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      push;
  logic                      dly_valid;
  logic                      dly_empty;

  flash_valid_delay #(
    .DEPTH(ROM_LATENCY)
  ) u_valid_delay (
    .clk      (clk),
    .reset    (reset),
    .valid_in (push),
    .valid_out(dly_valid),
    .empty    (dly_empty)
  );

  // command FSM: wait states, acceptance, beat issue, drain
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    be_d       = be_q;
    rom_addr_d = rom_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flash_mem_read) begin
          wait_cnt_d = WS_LOAD;
          // WAIT occupies exactly WAIT_STATES cycles
          if (WS_LOAD == 4'd0) state_d = ACK;
          else                 state_d = WAIT;
        end
      end
      WAIT: begin
        if (!flash_mem_read) begin
          state_d = IDLE;
        end else if (wait_cnt_q <= 4'd1) begin
          state_d = ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ACK: begin
        rom_addr_d = flash_mem_address;
        be_d       = flash_mem_byteenable;
        if (flash_mem_burstcount == '0)
          beat_cnt_d = FLASH_BURST_W'(1);
        else
          beat_cnt_d = flash_mem_burstcount;
        state_d = ISSUE;
      end
      ISSUE: begin
        push = 1'b1;
        if (beat_cnt_q == FLASH_BURST_W'(1)) begin
          state_d = DRAIN;
        end else begin
          beat_cnt_d = beat_cnt_q - FLASH_BURST_W'(1);
          rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (dly_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // return path: mask ROM word by captured byte enables
  always_comb begin
    rvalid_d = dly_valid;
    rdata_d  = rdata_q;
    if (dly_valid) begin
      for (int i = 0; i < 4; i++) begin
        rdata_d[8*i +: 8] = be_q[i] ? rom_q[8*i +: 8] : 8'h00;
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      be_q       <= '0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      be_q       <= be_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign flash_mem_waitrequest   = (state_q != ACK);
  assign flash_mem_readdata      = rdata_q;
  assign flash_mem_readdatavalid = rvalid_q;
  assign rom_address             = rom_addr_q;

endmodule

// File: tb/tb_flash_mem_responder.sv
// tb_flash_mem_responder: directed self-checking bench for
// the flash memory read responder.
module tb_flash_mem_responder;
  import flash_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] address = '0;
  logic        rd = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [6:0]  burst = '0;
  logic        wr;
  logic [31:0] rdata;
  logic        rdv;
  logic [22:0] rom_address;
  logic [31:0] rom_q = '0;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int ack_seen = 0;

  logic [31:0] beat_data [$];
  int          beat_cyc  [$];
  logic [22:0] addr_log  [int];

  flash_mem_responder #(
    .ADDR_W     (23),
    .WAIT_STATES(2),
    .ROM_LATENCY(1)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .flash_mem_address      (address),
    .flash_mem_read         (rd),
    .flash_mem_byteenable   (be),
    .flash_mem_burstcount   (burst),
    .flash_mem_waitrequest  (wr),
    .flash_mem_readdata     (rdata),
    .flash_mem_readdatavalid(rdv),
    .rom_address            (rom_address),
    .rom_q                  (rom_q)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [22:0] a);
    if (a == 23'h10) return 32'hDEADBEEF;
    return {8'hC3, 1'b0, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM image, one cycle latency
  always @(posedge clk) rom_q <= rom_word(rom_address);

  always @(negedge clk) begin
    addr_log[cyc] = rom_address;
    if (!wr) ack_seen++;
    if (rdv) begin
      beat_data.push_back(rdata);
      beat_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    beat_data.delete();
    beat_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(
    input  logic [22:0] a,
    input  logic [3:0]  b,
    input  logic [6:0]  n,
    output int          acc,
    output int          highs,
    output bit          ok
  );
    @(posedge clk); #1;
    address = a; be = b; burst = n; rd = 1'b1;
    acc = -1; highs = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!wr) begin ok = 1'b1; acc = cyc; end
      else highs++;
    end
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr !== 1'b1) begin errs++;
      $display("FAIL reset_wr got=%b exp=1", wr); end
    checks++;
    if (rdv !== 1'b0) begin errs++;
      $display("FAIL reset_rdv got=%b exp=0", rdv); end
    checks++;
    if (rdata !== 32'h0) begin errs++;
      $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++;
    if (rom_address !== 23'h0) begin errs++;
      $display("FAIL reset_romaddr got=%h exp=0", rom_address);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int acc, highs; bit ok;
    clear_log();
    issue_cmd(23'h10, 4'hF, 7'd1, acc, highs, ok);
    idle(15);
    checks++;
    if (!ok) begin errs++;
      $display("FAIL single_accept got=timeout exp=accept"); end
    checks++;
    if (highs != 3) begin errs++;
      $display("FAIL single_waits got=%0d exp=3", highs); end
    checks++;
    if (addr_log[acc+1] !== 23'h10) begin errs++;
      $display("FAIL single_addr got=%h exp=10", addr_log[acc+1]);
    end
    checks++;
    if (beat_data.size() != 1) begin errs++;
      $display("FAIL single_beats got=%0d exp=1", beat_data.size());
    end else begin
      checks++;
      if (beat_cyc[0] != acc + 3) begin errs++;
        $display("FAIL single_lat got=%0d exp=%0d",
                 beat_cyc[0], acc + 3); end
      checks++;
      if (beat_data[0] !== 32'hDEADBEEF) begin errs++;
        $display("FAIL single_data got=%h exp=deadbeef",
                 beat_data[0]); end
    end
  endtask

  task automatic test_byteenable();
    int acc, highs; bit ok;
    clear_log();
    issue_cmd(23'h10, 4'b0101, 7'd1, acc, highs, ok);
    idle(15);
    checks++;
    if (beat_data.size() != 1) begin errs++;
      $display("FAIL be_beats got=%0d exp=1", beat_data.size());
    end else begin
      checks++;
      if (beat_data[0] !== 32'h00AD00EF) begin errs++;
        $display("FAIL be_data got=%h exp=00ad00ef", beat_data[0]);
      end
    end
    checks++;
    if (rdata !== 32'h00AD00EF || rdv !== 1'b0) begin errs++;
      $display("FAIL be_hold got=%h/%b exp=00ad00ef/0", rdata, rdv);
    end
  endtask

  task automatic test_burst_wrap();
    int acc, highs; bit ok;
    logic [22:0] a;
    clear_log();
    issue_cmd(23'h7FFFFE, 4'hF, 7'd4, acc, highs, ok);
    idle(20);
    checks++;
    if (beat_data.size() != 4) begin errs++;
      $display("FAIL wrap_beats got=%0d exp=4", beat_data.size());
    end else begin
      a = 23'h7FFFFE;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (addr_log[acc+1+k] !== a) begin errs++;
          $display("FAIL wrap_addr%0d got=%h exp=%h",
                   k, addr_log[acc+1+k], a); end
        checks++;
        if (beat_cyc[k] != acc + 3 + k) begin errs++;
          $display("FAIL wrap_cyc%0d got=%0d exp=%0d",
                   k, beat_cyc[k], acc + 3 + k); end
        checks++;
        if (beat_data[k] !== rom_word(a)) begin errs++;
          $display("FAIL wrap_data%0d got=%h exp=%h",
                   k, beat_data[k], rom_word(a)); end
        a = a + 23'd1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, highs;
    bit ok1, ok2;
    clear_log();
    acc1 = -1; acc2 = -1; ok1 = 0; ok2 = 0; highs = 0;
    @(posedge clk); #1;
    address = 23'h20; be = 4'hF; burst = 7'd0; rd = 1'b1;
    for (int i = 0; i < 40 && !ok1; i++) begin
      @(negedge clk);
      if (!wr) begin ok1 = 1'b1; acc1 = cyc; end
    end
    @(posedge clk); #1;
    address = 23'h21; burst = 7'd1;
    for (int i = 0; i < 40 && !ok2; i++) begin
      @(negedge clk);
      if (!wr) begin ok2 = 1'b1; acc2 = cyc; end
      else highs++;
    end
    @(posedge clk); #1;
    rd = 1'b0;
    idle(15);
    checks++;
    if (!ok1 || !ok2) begin errs++;
      $display("FAIL b2b_accept got=%b%b exp=11", ok1, ok2); end
    checks++;
    if (acc2 != acc1 + 7) begin errs++;
      $display("FAIL b2b_acc2 got=%0d exp=%0d", acc2, acc1 + 7); end
    checks++;
    if (highs != 6) begin errs++;
      $display("FAIL b2b_highs got=%0d exp=6", highs); end
    checks++;
    if (beat_data.size() != 2) begin errs++;
      $display("FAIL b2b_beats got=%0d exp=2", beat_data.size());
    end else begin
      checks++;
      if (beat_cyc[0] != acc1 + 3 ||
          beat_data[0] !== rom_word(23'h20)) begin errs++;
        $display("FAIL b2b_beat0 got=%0d/%h exp=%0d/%h",
                 beat_cyc[0], beat_data[0], acc1 + 3,
                 rom_word(23'h20)); end
      checks++;
      if (beat_cyc[1] != acc2 + 3 ||
          beat_data[1] !== rom_word(23'h21)) begin errs++;
        $display("FAIL b2b_beat1 got=%0d/%h exp=%0d/%h",
                 beat_cyc[1], beat_data[1], acc2 + 3,
                 rom_word(23'h21)); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, highs; bit ok;
    clear_log();
    issue_cmd(23'h40, 4'hF, 7'd8, acc, highs, ok);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (wr !== 1'b1 || rdv !== 1'b0) begin errs++;
      $display("FAIL rstmid_now got=%b/%b exp=1/0", wr, rdv); end
    checks++;
    if (rom_address !== 23'h0) begin errs++;
      $display("FAIL rstmid_addr got=%h exp=0", rom_address); end
    idle(2);
    reset = 1'b0;
    idle(20);
    checks++;
    if (beat_data.size() != 0) begin errs++;
      $display("FAIL rstmid_beats got=%0d exp=0", beat_data.size());
    end
    clear_log();
    issue_cmd(23'h10, 4'hF, 7'd1, acc, highs, ok);
    idle(15);
    checks++;
    if (!ok || highs != 3) begin errs++;
      $display("FAIL rstmid_next_acc got=%b/%0d exp=1/3", ok, highs);
    end
    checks++;
    if (beat_data.size() != 1) begin errs++;
      $display("FAIL rstmid_next got=%0d exp=1", beat_data.size());
    end else begin
      checks++;
      if (beat_data[0] !== 32'hDEADBEEF ||
          beat_cyc[0] != acc + 3) begin errs++;
        $display("FAIL rstmid_next_data got=%h@%0d exp=deadbeef@%0d",
                 beat_data[0], beat_cyc[0], acc + 3); end
    end
  endtask

  task automatic test_drop_in_wait();
    int acks0;
    clear_log();
    acks0 = ack_seen;
    @(posedge clk); #1;
    address = 23'h30; be = 4'hF; burst = 7'd1; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    checks++;
    if (dut.state_q !== WAIT) begin errs++;
      $display("FAIL drop_wait got=%0d exp=%0d", dut.state_q, WAIT);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== IDLE) begin errs++;
      $display("FAIL drop_idle got=%0d exp=%0d", dut.state_q, IDLE);
    end
    idle(15);
    checks++;
    if (ack_seen != acks0 || beat_data.size() != 0) begin errs++;
      $display("FAIL drop_resp got=%0d/%0d exp=0/0",
               ack_seen - acks0, beat_data.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_byteenable();
    test_burst_wrap();
    test_back_to_back();
    test_drop_in_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
